// File: rtl/ar_fifo_reader.sv
// rtl/ar_fifo_reader.sv - AD sample FIFO reader with channel tagging and output stream buffer
module ar_fifo_reader #(
    parameter int DATA_W    = 16,
    parameter int NUM_CH    = 8,
    parameter int CH_W      = 3,
    parameter int BUF_DEPTH = 4,
    parameter int FRAME_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               ch_clr,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    output logic               fifo_rdreq,
    input  logic [DATA_W-1:0]  fifo_q,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic [CH_W-1:0]    m_ch,
    output logic               m_sof,
    output logic               m_eof,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               ovf_flag
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_V  = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    logic [DATA_W-1:0] buf_mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  buf_count;
    logic              rd_pend;
    logic [CH_W-1:0]   ch;
    logic              push;
    logic              pop;

    // A read is only issued when the buffer has room for it plus any read still in flight,
    // so the buffer can never overflow regardless of downstream backpressure.
    assign fifo_rdreq = !reset && enable && !fifo_empty
                        && (({1'b0, buf_count} + (CNT_W + 1)'(rd_pend)) < DEPTH_V);

    assign push    = rd_pend;
    assign m_valid = (buf_count != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? buf_mem[rd_ptr] : '0;
    assign m_ch    = ch;
    assign m_sof   = (ch == '0);
    assign m_eof   = (ch == CH_LAST);

    // Remember last cycle's read request: fifo_q carries that word this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fifo_rdreq;
        end
    end

    // Buffer storage: capture the FIFO word at the tail when a read is pending.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            buf_mem[wr_ptr] <= fifo_q;
        end
    end

    // Buffer pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   buf_count <= buf_count + CNT_W'(1);
                2'b01:   buf_count <= buf_count - CNT_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Channel tag advances per handshake; a realign pulse overrides the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch <= '0;
        end else if (ch_clr) begin
            ch <= '0;
        end else if (pop) begin
            ch <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
        end
    end

    // Count frames completed at the handshake of the last channel, even during a realign.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (pop && m_eof) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    // Sticky record that the writer side ever hit full.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_flag <= 1'b0;
        end else if (fifo_full) begin
            ovf_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ar_fifo_reader.sv
// tb/tb_ar_fifo_reader.sv - testbench for ar_fifo_reader
module tb_ar_fifo_reader;

    localparam int DATA_W    = 16;
    localparam int NUM_CH    = 8;
    localparam int CH_W      = 3;
    localparam int BUF_DEPTH = 4;
    localparam int FRAME_W   = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               ch_clr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_rdreq;
    logic [DATA_W-1:0]  fifo_q;
    logic               m_valid;
    logic               m_ready;
    logic [DATA_W-1:0]  m_data;
    logic [CH_W-1:0]    m_ch;
    logic               m_sof;
    logic               m_eof;
    logic [FRAME_W-1:0] frame_cnt;
    logic               ovf_flag;

    ar_fifo_reader #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W),
        .BUF_DEPTH(BUF_DEPTH), .FRAME_W(FRAME_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_clr(ch_clr),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_rdreq(fifo_rdreq),
        .fifo_q(fifo_q), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_ch(m_ch), .m_sof(m_sof), .m_eof(m_eof), .frame_cnt(frame_cnt),
        .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source FIFO contents and reference model state.
    logic [DATA_W-1:0] src_q [$];
    logic [DATA_W-1:0] exp_q [$];
    int                vis_q [$];
    int                ch_m;
    int                frame_m;
    bit                ovf_m;
    int                cyc_n;
    int                rd_cnt, hs_cnt, first_rd, first_hs, last_hs;
    logic [DATA_W-1:0] word_seq;

    typedef struct {
        bit do_rst;
        int words;
        bit en;
        bit rdy;
        int ncyc;
        int exp_hs;
        int exp_rd;
        int exp_frame;
        int exp_lat;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            src_q.push_back(word_seq);
            word_seq = word_seq + 1'b1;
        end
    endtask

    // One clock cycle: inputs already set, called at the falling edge.
    task automatic cyc();
        bit rd, exp_valid, mhs;
        logic [DATA_W-1:0] w;
        fifo_empty = (src_q.size() == 0);
        #1;
        rd        = fifo_rdreq;
        exp_valid = (exp_q.size() > 0) && (vis_q[0] <= cyc_n);
        mhs       = exp_valid && m_ready;
        if (reset) begin
            chk("rdreq_in_reset", fifo_rdreq, 0);
        end else begin
            chk("rdreq", fifo_rdreq,
                enable && (src_q.size() > 0) && (exp_q.size() < BUF_DEPTH));
            chk("m_valid", m_valid, exp_valid);
            if (exp_valid) begin
                chk("m_data", m_data, exp_q[0]);
                chk("m_ch", m_ch, ch_m);
                chk("m_sof", m_sof, ch_m == 0);
                chk("m_eof", m_eof, ch_m == NUM_CH - 1);
            end
            chk("frame_cnt", frame_cnt, frame_m);
            chk("ovf_flag", ovf_flag, ovf_m);
            if (rd) begin
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc_n;
            end
            if (mhs) begin
                hs_cnt++;
                if (first_hs < 0) first_hs = cyc_n;
                last_hs = cyc_n;
            end
        end
        @(posedge clk);
        #1;
        if (rd && src_q.size() > 0) begin
            w = src_q.pop_front();
            fifo_q = w;
        end
        if (reset) begin
            exp_q.delete();
            vis_q.delete();
            ch_m = 0;
            frame_m = 0;
            ovf_m = 0;
        end else begin
            if (mhs) begin
                if (ch_m == NUM_CH - 1) frame_m = (frame_m + 1) % (1 << FRAME_W);
                void'(exp_q.pop_front());
                void'(vis_q.pop_front());
            end
            if (ch_clr) ch_m = 0;
            else if (mhs) ch_m = (ch_m + 1) % NUM_CH;
            if (fifo_full) ovf_m = 1;
            if (rd) begin
                exp_q.push_back(w);
                vis_q.push_back(cyc_n + 2);
            end
        end
        cyc_n++;
        fifo_empty = (src_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic clr_stats();
        rd_cnt = 0; hs_cnt = 0; first_rd = -1; first_hs = -1; last_hs = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        src_q.delete();
        word_seq = 16'h0001;
    endtask

    initial begin
        bit found;
        reset = 1'b1; enable = 1'b0; ch_clr = 1'b0; fifo_full = 1'b0;
        fifo_empty = 1'b1; fifo_q = '0; m_ready = 1'b0;
        ch_m = 0; frame_m = 0; ovf_m = 0; cyc_n = 0; word_seq = 16'h0001;
        clr_stats();

        //            rst words en rdy ncyc hs rd frame lat
        vecs[0] = '{1, 16, 1, 1, 24, 16, 16, 2, 2};
        vecs[1] = '{1, 10, 1, 0, 10,  0,  4, 0, -1};
        vecs[2] = '{0,  0, 1, 1, 16, 10,  6, 1, -1};
        vecs[3] = '{1,  1, 1, 1,  8,  1,  1, 0, 2};
        vecs[4] = '{1,  5, 0, 1,  6,  0,  0, 0, -1};
        vecs[5] = '{0,  0, 1, 1, 10,  5,  5, 0, 2};

        @(negedge clk);
        cyc();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ch", m_ch, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_ovf", ovf_flag, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].do_rst) do_reset();
            load(vecs[v].words);
            enable  = vecs[v].en;
            m_ready = vecs[v].rdy;
            clr_stats();
            for (int c = 0; c < vecs[v].ncyc; c++) cyc();
            chk($sformatf("vec%0d_hs", v), hs_cnt, vecs[v].exp_hs);
            chk($sformatf("vec%0d_rd", v), rd_cnt, vecs[v].exp_rd);
            chk($sformatf("vec%0d_frame", v), frame_cnt, vecs[v].exp_frame);
            if (vecs[v].exp_lat >= 0) begin
                chk($sformatf("vec%0d_latency", v), first_hs - first_rd, vecs[v].exp_lat);
                chk($sformatf("vec%0d_rate", v), last_hs - first_hs, vecs[v].exp_hs - 1);
            end
        end

        // Realign: ch_clr together with the handshake of channel 5.
        do_reset();
        load(12);
        enable = 1'b1; m_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (m_valid && m_ch == 3'd5) found = 1;
            else cyc();
        end
        chk("clr_found_ch5", found, 1);
        ch_clr = 1'b1;
        cyc();
        ch_clr = 1'b0;
        chk("clr_m_ch", m_ch, 0);
        chk("clr_m_sof", m_sof, 1);
        chk("clr_frame", frame_cnt, 0);
        for (int c = 0; c < 12; c++) cyc();

        // Enable drop right after a read was issued.
        do_reset();
        load(3);
        enable = 1'b1; m_ready = 1'b1;
        clr_stats();
        cyc();
        chk("endrop_first_rd", rd_cnt, 1);
        enable = 1'b0;
        clr_stats();
        for (int c = 0; c < 8; c++) cyc();
        chk("endrop_hs", hs_cnt, 1);
        chk("endrop_rd", rd_cnt, 0);
        chk("endrop_left", src_q.size(), 2);
        enable = 1'b1;
        for (int c = 0; c < 8; c++) cyc();

        // Overflow flag, then reset with samples buffered.
        fifo_full = 1'b1;
        cyc();
        fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) cyc();
        chk("ovf_sticky", ovf_flag, 1);
        load(2);
        m_ready = 1'b0;
        for (int c = 0; c < 4; c++) cyc();
        chk("pre_rst_valid", m_valid, 1);
        do_reset();
        chk("midrst_valid", m_valid, 0);
        chk("midrst_frame", frame_cnt, 0);
        chk("midrst_ovf", ovf_flag, 0);
        chk("midrst_data", m_data, 0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 40 && src_q.size() < 64) load(1);
            enable    = ($urandom_range(0, 9) != 0);
            m_ready   = ($urandom_range(0, 2) != 0);
            ch_clr    = ($urandom_range(0, 49) == 0);
            fifo_full = ($urandom_range(0, 199) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            cyc();
        end
        reset = 1'b0; ch_clr = 1'b0; fifo_full = 1'b0; enable = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 80; c++) cyc();
        chk("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ar_fifo_reader.md
Name: ar_fifo_reader

Overview:
Drains the AD sample FIFO, which the AD capture path fills, and is the reader counterpart to that writer. The FIFO read port is Altera normal mode: read latency 1, no show-ahead. The block tags each popped sample with its channel index and frame markers. It presents samples on a valid/ready stream to the downstream filter, with an internal buffer that absorbs read latency and backpressure.

Parameters:
DATA_W, 16, sample width (FIFO q and m_data)
NUM_CH, 8, channels per conversion frame (≥2)
CH_W, 3, channel index width, ≥ clog2(NUM_CH)
BUF_DEPTH, 4, output buffer entries (≥2; full throughput needs ≥3)
FRAME_W, 16, frame counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enable  in  1  1 = issue FIFO reads; 0 = stop new reads, in-flight read still completes
ch_clr  in  1  one-cycle pulse that forces the channel counter to 0 (frame realign)
fifo_empty  in  1  FIFO read-side empty
fifo_full  in  1  FIFO write-side full, already synced into clk
fifo_rdreq  out  1  FIFO read request, combinational
fifo_q  in  DATA_W  FIFO data, valid the cycle after rdreq
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts
m_data  out  DATA_W  sample
m_ch  out  CH_W  channel index of m_data
m_sof  out  1  m_ch==0
m_eof  out  1  m_ch==NUM_CH-1
frame_cnt  out  FRAME_W  completed frames
ovf_flag  out  1  sticky; FIFO full was seen

Behaviour:
- Reset values, applied at the clk edge while reset=1:
  - m_valid=0, m_data=0, m_ch=0, frame_cnt=0, ovf_flag=0.
  - Buffer empty, rd_pend=0.
  - fifo_rdreq=0 combinationally while reset=1.
- rd_pend is a register equal to the previous-cycle fifo_rdreq.
- Read issue: fifo_rdreq = !reset & enable & !fifo_empty & (buf_count + rd_pend < BUF_DEPTH).
  - buf_count and rd_pend are registered; the expression never depends on m_ready.
  - The buffer can therefore never overflow, and no read is issued while empty.
- Capture: when rd_pend=1, fifo_q is written into the buffer tail at that edge.
- Latency: rdreq high in cycle n → sample in buffer end of n+1 → m_valid=1 in cycle n+2 if the buffer was empty.
- Throughput: with BUF_DEPTH≥3, empty=0 and m_ready=1 held, one sample per clk in steady state.
- Buffer:
  - FIFO-ordered, BUF_DEPTH entries. m_data is the head; m_valid = (buf_count≠0).
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop leaves buf_count unchanged. Push into an empty buffer while popping is impossible, since m_valid=0.
  - m_data/m_ch hold stable while m_valid & !m_ready.
- Channel counter ch:
  - Increments on each output handshake and wraps NUM_CH-1 → 0.
  - m_ch = ch, m_sof = (ch==0), m_eof = (ch==NUM_CH-1).
- frame_cnt: +1 on a handshake with m_eof=1; wraps 2^FRAME_W-1 → 0.
- ch_clr:
  - ch=0 at the next edge, and ch_clr wins over a same-cycle handshake increment.
  - A same-cycle handshake still pops, and frame_cnt still counts it if it had m_eof.
  - Buffered data is not discarded.
- ovf_flag: set on any cycle with fifo_full=1; cleared only by reset.
- enable drop mid-stream: rdreq goes low immediately. A pending read (rd_pend=1) is still captured, and buffered samples still drain.
- Reset mid-operation: the buffer and the pending read are discarded. A word popped from the FIFO in the reset cycle or the cycle before is lost; this is accepted.

Test Plan:
1. Reset with FIFO holding 0x0001..0x0010, enable=1, m_ready=1, NUM_CH=8 → first m_valid 2 cycles after first rdreq; data 0x0001..0x0010 in order, 1/cycle; m_ch 0..7,0..7; frame_cnt=2.
2. Backpressure: m_ready=0 for 10 cycles with FIFO non-empty → at most BUF_DEPTH=4 rdreq pulses then rdreq=0; m_data frozen; release → remaining data in order, no loss or duplicate.
3. FIFO with 1 word, enable=1 → exactly one rdreq pulse; after the pop, empty=1 and rdreq stays 0; m_data equals that word.
4. ch_clr pulse asserted together with the handshake of m_ch=5 → next sample m_ch=0, m_sof=1; frame_cnt unchanged.
5. enable toggled 1→0 in the same cycle as rdreq=1 → that word still appears on m_data; no further rdreq until enable=1.
6. fifo_full=1 for one cycle → ovf_flag=1, held until reset; reset asserted with 2 words buffered → m_valid=0, frame_cnt=0 the next cycle.
